// File: rtl/polara_switch_pkg.sv
// Shared types for the Polara switch event controller: press FSM states and
// the queued event record.
package polara_switch_pkg;

  // Widest switch index supported (N_SW up to 8)
  localparam int unsigned SW_IDX_MAX_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    LONG_HELD
  } press_state_e;

  typedef struct packed {
    logic [SW_IDX_MAX_W-1:0] sw;
    logic                    is_long;
  } sw_evt_t;

  function automatic int unsigned sw_idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/polara_switch_press_fsm.sv
// Per-switch press classifier: turns one debounced level into a single
// short or long event per press.
module polara_switch_press_fsm
  import polara_switch_pkg::*;
#(
  parameter int unsigned LONG_CYCLES = 40_000_000
) (
  input  logic clk,
  input  logic rstn,
  input  logic sw_db,
  output logic evt_pulse,
  output logic evt_long
);

  localparam int unsigned CNT_W = $clog2(LONG_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LONG_CYCLES - 1);

  press_state_e     state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             sw_prev;

  // sw_prev tracks the input during reset so a switch held through reset stays silent
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      sw_prev <= sw_db;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      sw_prev <= sw_db;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    evt_pulse = 1'b0;
    evt_long  = 1'b0;
    case (state)
      IDLE: begin
        if (sw_db && !sw_prev) begin
          state_n = PRESSED;
          cnt_n   = '0;
        end
      end
      PRESSED: begin
        if (!sw_db) begin
          evt_pulse = 1'b1;
          state_n   = IDLE;
        end else if (cnt == CNT_LAST) begin
          evt_pulse = 1'b1;
          evt_long  = 1'b1;
          state_n   = LONG_HELD;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      LONG_HELD: begin
        if (!sw_db) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: rtl/polara_switch_event_ctrl.sv
// Switch event controller: per-switch press FSMs, pending latches, a
// fixed-priority arbiter and a small event FIFO with a valid/ready output.
module polara_switch_event_ctrl
  import polara_switch_pkg::*;
#(
  parameter int unsigned N_SW        = 4,
  parameter int unsigned LONG_CYCLES = 40_000_000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [N_SW-1:0]             i_sw_db,
  output logic                        o_evt_valid,
  input  logic                        i_evt_ready,
  output logic [sw_idx_w(N_SW)-1:0]   o_evt_sw,
  output logic                        o_evt_long,
  output logic                        o_overflow
);

  localparam int unsigned SW_W  = sw_idx_w(N_SW);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [N_SW-1:0] evt_pulse, evt_long;
  logic [N_SW-1:0] pending, pending_n, long_flag, new_evt, grant;
  logic [SW_W-1:0] grant_idx;
  logic            found, push, pop, full;
  sw_evt_t         push_evt, head;

  sw_evt_t          mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  for (genvar g = 0; g < N_SW; g++) begin : g_sw
    polara_switch_press_fsm #(
      .LONG_CYCLES(LONG_CYCLES)
    ) u_fsm (
      .clk       (clk),
      .rstn      (rstn),
      .sw_db     (i_sw_db[g]),
      .evt_pulse (evt_pulse[g]),
      .evt_long  (evt_long[g])
    );
  end

  assign full        = (count == CNT_W'(FIFO_DEPTH));
  assign o_evt_valid = (count != '0);
  assign pop         = o_evt_valid && i_evt_ready;
  assign new_evt     = evt_pulse & ~pending;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < N_SW; i++) begin
      if (pending[i] && !found) begin
        found     = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = SW_W'(i);
      end
    end
    // A pop frees a slot in the same cycle, so a full FIFO still accepts
    push             = found && (!full || pop);
    push_evt.sw      = SW_IDX_MAX_W'(grant_idx);
    push_evt.is_long = long_flag[grant_idx];
    pending_n        = (pending & ~(push ? grant : '0)) | new_evt;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pending    <= '0;
      long_flag  <= '0;
      o_overflow <= 1'b0;
    end else begin
      pending   <= pending_n;
      long_flag <= (long_flag & ~new_evt) | (evt_long & new_evt);
      if (|(evt_pulse & pending)) o_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_evt;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head       = mem[rd_ptr];
  assign o_evt_sw   = SW_W'(head.sw);
  assign o_evt_long = head.is_long;

endmodule

// File: tb/tb_polara_switch_event_ctrl.sv
// Directed bench for polara_switch_event_ctrl with LONG_CYCLES=16, N_SW=4,
// FIFO_DEPTH=4: a press table plus hand-written multi-cycle sequences.
module tb_polara_switch_event_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] sw;
  logic       ready;
  logic       valid;
  logic [1:0] evt_sw;
  logic       evt_long;
  logic       ovf;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int unsigned idx;
    int unsigned hold;
    logic        exp_long;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];

  polara_switch_event_ctrl #(
    .N_SW       (4),
    .LONG_CYCLES(16),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .i_sw_db     (sw),
    .o_evt_valid (valid),
    .i_evt_ready (ready),
    .o_evt_sw    (evt_sw),
    .o_evt_long  (evt_long),
    .o_overflow  (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Press one switch for v.hold cycles (ready=1) and time the resulting event
  task automatic run_vec(input vec_t v);
    int first = -1;
    int nval  = 0;
    int g_sw  = -1;
    int g_lng = -1;
    for (int c = 0; c <= int'(v.hold) + 8; c++) begin
      sw = (c < int'(v.hold)) ? 4'(1 << v.idx) : 4'b0000;
      tick();
      if (valid) begin
        nval++;
        if (first < 0) begin
          first = c + 1;
          g_sw  = int'(evt_sw);
          g_lng = int'(evt_long);
        end
      end
    end
    sw = '0;
    chk($sformatf("vec sw%0d hold%0d latency", v.idx, v.hold), first, v.exp_lat);
    chk($sformatf("vec sw%0d hold%0d index", v.idx, v.hold), g_sw, int'(v.idx));
    chk($sformatf("vec sw%0d hold%0d long", v.idx, v.hold), g_lng, int'(v.exp_long));
    chk($sformatf("vec sw%0d hold%0d count", v.idx, v.hold), nval, 1);
    repeat (3) tick();
  endtask

  initial begin
    int nval;
    int exp_order[5];

    vecs[0] = '{idx: 1, hold: 5,  exp_long: 1'b0, exp_lat: 7};
    vecs[1] = '{idx: 2, hold: 40, exp_long: 1'b1, exp_lat: 18};
    vecs[2] = '{idx: 0, hold: 16, exp_long: 1'b0, exp_lat: 18};
    vecs[3] = '{idx: 0, hold: 17, exp_long: 1'b1, exp_lat: 18};
    vecs[4] = '{idx: 3, hold: 1,  exp_long: 1'b0, exp_lat: 3};
    vecs[5] = '{idx: 2, hold: 2,  exp_long: 1'b0, exp_lat: 4};
    vecs[6] = '{idx: 3, hold: 20, exp_long: 1'b1, exp_lat: 18};
    exp_order = '{0, 1, 2, 3, 0};

    rstn  = 1'b0;
    sw    = '0;
    ready = 1'b1;
    repeat (3) tick();
    chk("reset valid", int'(valid), 0);
    chk("reset sw", int'(evt_sw), 0);
    chk("reset long", int'(evt_long), 0);
    chk("reset overflow", int'(ovf), 0);
    rstn = 1'b1;
    repeat (2) tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Simultaneous release of sw0 and sw3
    sw = 4'b1001;
    repeat (5) tick();
    sw = '0;
    tick();
    chk("simul e+1 valid", int'(valid), 0);
    tick();
    chk("simul first valid", int'(valid), 1);
    chk("simul first sw", int'(evt_sw), 0);
    chk("simul first long", int'(evt_long), 0);
    tick();
    chk("simul second valid", int'(valid), 1);
    chk("simul second sw", int'(evt_sw), 3);
    chk("simul second long", int'(evt_long), 0);
    tick();
    chk("simul drained", int'(valid), 0);
    repeat (3) tick();

    // Backpressure: fill the FIFO, leave one pending, then overflow it
    ready = 1'b0;
    sw = 4'b1111;
    repeat (3) tick();
    sw = '0;
    repeat (6) tick();
    sw = 4'b0001;
    repeat (3) tick();
    sw = '0;
    repeat (4) tick();
    chk("bp full valid", int'(valid), 1);
    chk("bp head sw", int'(evt_sw), 0);
    chk("bp no overflow yet", int'(ovf), 0);
    sw = 4'b0001;
    repeat (3) tick();
    sw = '0;
    repeat (3) tick();
    chk("bp overflow set", int'(ovf), 1);
    chk("bp head stable", int'(evt_sw), 0);
    ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("drain %0d valid", k), int'(valid), 1);
      chk($sformatf("drain %0d sw", k), int'(evt_sw), exp_order[k]);
      chk($sformatf("drain %0d long", k), int'(evt_long), 0);
      tick();
    end
    chk("drain empty", int'(valid), 0);
    chk("overflow sticky", int'(ovf), 1);

    // Reset mid-press on sw2 with a long sw3 event queued
    ready = 1'b0;
    sw = 4'b1000;
    repeat (20) tick();
    sw = '0;
    repeat (3) tick();
    chk("pre-reset valid", int'(valid), 1);
    chk("pre-reset sw", int'(evt_sw), 3);
    chk("pre-reset long", int'(evt_long), 1);
    sw = 4'b0100;
    repeat (5) tick();
    rstn = 1'b0;
    tick();
    chk("midreset valid", int'(valid), 0);
    chk("midreset sw", int'(evt_sw), 0);
    chk("midreset long", int'(evt_long), 0);
    chk("midreset overflow", int'(ovf), 0);
    rstn  = 1'b1;
    ready = 1'b1;
    nval  = 0;
    repeat (25) begin tick(); if (valid) nval++; end
    sw = '0;
    repeat (6) begin tick(); if (valid) nval++; end
    chk("midreset silent", nval, 0);

    // sw1 held through reset deassertion
    rstn = 1'b0;
    sw   = 4'b0010;
    repeat (3) tick();
    rstn = 1'b1;
    nval = 0;
    repeat (20) begin tick(); if (valid) nval++; end
    sw = '0;
    repeat (6) begin tick(); if (valid) nval++; end
    chk("held-through-reset silent", nval, 0);

    run_vec('{idx: 1, hold: 3, exp_long: 1'b0, exp_lat: 5});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
